// File: rtl/bus_req_bridge.sv
// Host-side request/response front end of the ghostbus: one transaction at a time, fixed read latency.
// Optional write responses are enabled by defining BUS_REQ_BRIDGE_WRESP_EN.
module bus_req_bridge #(
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          o_clk,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    input  logic [DW-1:0] o_rdata,
    output logic          o_wstb
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Latency counter is 4 bits; READ_LAT is legal only in 0..15.
    localparam logic [3:0] LAT_C = READ_LAT[3:0];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wstb_q, wstb_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstb_d   = 1'b0;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        wdata_d = req_wdata;
                        wstb_d  = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
`ifdef BUS_REQ_BRIDGE_WRESP_EN
                rdata_d  = '0;
                rvalid_d = 1'b1;
                state_d  = ST_RESP;
`else
                state_d  = ST_IDLE;
`endif
            end
            ST_READ: begin
                if (cnt_q == LAT_C) begin
                    rdata_d  = o_rdata;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                rvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstb_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstb_q   <= wstb_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign o_clk      = clk;
    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_wstb     = wstb_q;

endmodule

// File: tb/tb_bus_req_bridge.sv
// Scoreboard bench for bus_req_bridge: a READ_LAT=1 instance with a registered peripheral
// and a READ_LAT=0 instance with a combinational peripheral.
module tb_bus_req_bridge;

`ifdef BUS_REQ_BRIDGE_WRESP_EN
    localparam bit WRESP = 1'b1;
`else
    localparam bit WRESP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        o_clk, o_wstb;
    logic [23:0] o_addr;
    logic [31:0] o_wdata, o_rdata;

    logic        z_req_valid, z_req_ready, z_resp_valid, z_o_clk, z_o_wstb;
    logic [23:0] z_o_addr;
    logic [31:0] z_resp_rdata, z_o_wdata, z_o_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] extra  = 32'h0;
    logic [31:0] periph_q;
    logic [55:0] wq[$];
    logic [31:0] rq[$];
    bit          prev_wstb = 1'b0;

    always #5 clk = ~clk;

    bus_req_bridge #(.AW(24), .DW(32), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .o_clk(o_clk), .o_addr(o_addr), .o_wdata(o_wdata), .o_rdata(o_rdata), .o_wstb(o_wstb)
    );

    bus_req_bridge #(.AW(24), .DW(32), .READ_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(1'b0), .req_addr(24'h000005), .req_wdata(32'h0),
        .resp_valid(z_resp_valid), .resp_ready(1'b1), .resp_rdata(z_resp_rdata),
        .o_clk(z_o_clk), .o_addr(z_o_addr), .o_wdata(z_o_wdata), .o_rdata(z_o_rdata), .o_wstb(z_o_wstb)
    );

    // Peripherals: registered one-cycle return, and a purely combinational one.
    always @(posedge clk) periph_q <= {8'h00, o_addr} + 32'h100 + extra;
    assign o_rdata   = periph_q;
    assign z_o_rdata = {8'h00, z_o_addr} + 32'h100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every completed response must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got rdata %h expected no response", resp_rdata);
            end else begin
                logic [31:0] e;
                e = rq.pop_front();
                if (resp_rdata !== e) begin
                    errors++;
                    $display("FAIL resp_rdata: got %h expected %h", resp_rdata, e);
                end
            end
        end
    end

    // Bus write monitor: each strobe must carry the next queued address/data, one cycle wide.
    always @(negedge clk) begin
        if (o_wstb === 1'b1) begin
            checks++;
            if (prev_wstb) begin
                errors++;
                $display("FAIL wstb_width: got 2+ cycles expected 1");
            end else if (wq.size() == 0) begin
                errors++;
                $display("FAIL wstb_unexpected: got addr %h expected no write", o_addr);
            end else begin
                logic [55:0] e;
                e = wq.pop_front();
                if ({o_addr, o_wdata} !== e) begin
                    errors++;
                    $display("FAIL bus_write: got %h expected %h", {o_addr, o_wdata}, e);
                end
            end
        end
        prev_wstb = (o_wstb === 1'b1);
    end

    task automatic send(input bit wr, input logic [23:0] a, input logic [31:0] d, output int waits);
        bit done;
        done      = 1'b0;
        waits     = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        if (wr) begin
            wq.push_back({a, d});
            if (WRESP) rq.push_back(32'h0);
        end else begin
            rq.push_back({8'h00, a} + 32'h100);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                done = 1'b1;
                break;
            end
            waits++;
        end
        if (!done) begin
            errors++;
            $display("FAIL handshake_timeout: got no req_ready expected handshake");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int w;
        bit seen;
        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = 24'h123456;
        req_wdata   = 32'h11223344;
        resp_ready  = 1'b1;
        z_req_valid = 1'b0;

        // Reset held with a pending request: nothing may take effect.
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
            chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
            chk("rst_o_wstb", {63'd0, o_wstb}, 64'd0);
            chk("rst_o_addr", {40'd0, o_addr}, 64'd0);
        end
        chk("o_clk_follows", {63'd0, o_clk}, 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;

        // Single write.
        send(1'b1, 24'h000010, 32'hDEADBEEF, w);
        @(negedge clk);
        chk("wr_wstb_hi", {63'd0, o_wstb}, 64'd1);
        chk("wr_o_addr", {40'd0, o_addr}, 64'h10);
        chk("wr_o_wdata", {32'd0, o_wdata}, 64'hDEADBEEF);
        chk("wr_req_ready_busy", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        chk("wr_wstb_lo", {63'd0, o_wstb}, 64'd0);
        chk("wr_req_ready_back", {63'd0, req_ready}, WRESP ? 64'd0 : 64'd1);
        chk("wr_resp_valid", {63'd0, resp_valid}, WRESP ? 64'd1 : 64'd0);
        @(posedge clk);
        #1;

        // Read with READ_LAT=1: response two cycles after the handshake.
        send(1'b0, 24'h000020, 32'h0, w);
        @(negedge clk);
        chk("rd_lat_c1", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        chk("rd_lat_c2", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        chk("rd_lat_c3", {63'd0, resp_valid}, 64'd1);
        chk("rd_rdata", {32'd0, resp_rdata}, 64'h120);
        @(negedge clk);
        chk("rd_no_dup", {63'd0, resp_valid}, 64'd0);

        // READ_LAT=0 instance with combinational peripheral.
        @(posedge clk);
        #1;
        z_req_valid = 1'b1;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        @(negedge clk);
        chk("rd0_lat_c1", {63'd0, z_resp_valid}, 64'd0);
        @(negedge clk);
        chk("rd0_lat_c2", {63'd0, z_resp_valid}, 64'd1);
        chk("rd0_rdata", {32'd0, z_resp_rdata}, 64'h105);
        @(negedge clk);
        chk("rd0_no_dup", {63'd0, z_resp_valid}, 64'd0);

        // Back-to-back writes.
        @(posedge clk);
        #1;
        send(1'b1, 24'h0000A0, 32'h01020304, w);
        send(1'b1, 24'h0000A4, 32'h05060708, w);
        chk("b2b_wait", w, WRESP ? 64'd2 : 64'd1);

        // Response backpressure while peripheral data moves.
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        send(1'b0, 24'h000030, 32'h0, w);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_resp_seen", {63'd0, seen}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            extra = extra + 32'h11;
            @(negedge clk);
            chk("bp_valid_held", {63'd0, resp_valid}, 64'd1);
            chk("bp_rdata_held", {32'd0, resp_rdata}, 64'h130);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        extra      = 32'h0;
        resp_ready = 1'b1;
        // Request held through RESP is taken in the first IDLE cycle.
        send(1'b1, 24'h000040, 32'hCAFEF00D, w);
        chk("held_req_wait", w, 64'd1);

        // Reset in the middle of a write: strobe already issued, dropped at the reset edge.
        repeat (3) @(posedge clk);
        #1;
        send(1'b1, 24'h000050, 32'h55AA55AA, w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (WRESP) void'(rq.pop_back());
        @(negedge clk);
        chk("rst_wr_wstb", {63'd0, o_wstb}, 64'd0);
        chk("rst_wr_ready", {63'd0, req_ready}, 64'd1);

        // Reset in the middle of a read: the response is dropped.
        send(1'b0, 24'h000060, 32'h0, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(rq.pop_back());
        @(negedge clk);
        chk("rst_rd_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_rd_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        chk("rst_rd_quiet", {63'd0, resp_valid}, 64'd0);

        repeat (5) @(negedge clk);
        chk("resp_queue_drained", rq.size(), 64'd0);
        chk("write_queue_drained", wq.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
